// File: rtl/ccm_pkg.sv
// Shared definitions for the CCM counter-mode XOR stage: default widths, FSM encoding, byte mask.
package ccm_pkg;

    localparam int unsigned CCM_WIDTH_KEY   = 128;
    localparam int unsigned CCM_WIDTH_BYTES = 4;
    localparam int unsigned CCM_KEY_BYTES   = CCM_WIDTH_KEY / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } ccm_state_e;

    // Keep-mask for a partial last block: byte 0 is the MS byte; bytes == 0 keeps the whole block.
    function automatic logic [CCM_WIDTH_KEY-1:0] mask_bytes(input logic [CCM_WIDTH_BYTES-1:0] bytes);
        logic [CCM_WIDTH_KEY-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CCM_KEY_BYTES; i++) begin
            m = {m[CCM_WIDTH_KEY-9:0],
                 ((bytes == '0) || (i < 32'(bytes))) ? 8'hFF : 8'h00};
        end
        return m;
    endfunction

endpackage

// File: rtl/ccm_ctr_xor_fifo.sv
// Synchronous payload FIFO; pointers carry one extra wrap bit to tell full from empty.
module ccm_ctr_xor_fifo #(
    parameter int unsigned WIDTH = 133,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             kill_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ccm_ctr_xor_stage.sv
// CCM counter-mode XOR stage: FIFO-buffered payload, one keystream request per block, valid/ready out.
// Optional CCM_CTR_BYTE_MASK_EN zeroes the unused tail bytes of a short final block.
module ccm_ctr_xor_stage
    import ccm_pkg::*;
#(
    parameter int unsigned WIDTH_KEY   = CCM_WIDTH_KEY,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WIDTH_BYTES = CCM_WIDTH_BYTES
) (
    input  logic                   clk,
    input  logic                   kill_n,
    input  logic [WIDTH_KEY-1:0]   din,
    input  logic                   din_last,
    input  logic [WIDTH_BYTES-1:0] din_bytes,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   ks_req,
    input  logic [WIDTH_KEY-1:0]   ks_data,
    input  logic                   ks_en,
    output logic [WIDTH_KEY-1:0]   dout,
    output logic                   dout_last,
    output logic [WIDTH_BYTES-1:0] dout_bytes,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic                   err_ks
);

    localparam int unsigned FW = WIDTH_KEY + WIDTH_BYTES + 1;

    ccm_state_e             state_q, state_d;
    logic [WIDTH_KEY-1:0]   work_data_q, work_data_d;
    logic                   work_last_q, work_last_d;
    logic [WIDTH_BYTES-1:0] work_bytes_q, work_bytes_d;
    logic [WIDTH_KEY-1:0]   dout_q, dout_d;
    logic                   dout_last_q, dout_last_d;
    logic [WIDTH_BYTES-1:0] dout_bytes_q, dout_bytes_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   ks_req_q, ks_req_d;
    logic                   err_ks_q, err_ks_d;

    logic [FW-1:0]          fifo_rd_data;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    logic [WIDTH_KEY-1:0]   xor_c;
`ifdef CCM_CTR_BYTE_MASK_EN
    logic [CCM_WIDTH_KEY-1:0] mask_c;
`endif

    assign push = din_valid && !fifo_full;

    ccm_ctr_xor_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .kill_n  (kill_n),
        .wr_en   (push),
        .wr_data ({din_last, din_bytes, din}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Keystream XOR, with optional tail-byte clearing on a short final block.
    always_comb begin
        xor_c = work_data_q ^ ks_data;
`ifdef CCM_CTR_BYTE_MASK_EN
        mask_c = mask_bytes(CCM_WIDTH_BYTES'(work_bytes_q));
        if (work_last_q && (work_bytes_q != '0)) begin
            xor_c = xor_c & mask_c[CCM_WIDTH_KEY-1 -: WIDTH_KEY];
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        work_data_d  = work_data_q;
        work_last_d  = work_last_q;
        work_bytes_d = work_bytes_q;
        dout_d       = dout_q;
        dout_last_d  = dout_last_q;
        dout_bytes_d = dout_bytes_q;
        dout_valid_d = dout_valid_q;
        pop          = 1'b0;
        err_ks_d     = ks_en && (state_q != ST_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    {work_last_d, work_bytes_d, work_data_d} = fifo_rd_data;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (ks_en) begin
                    dout_d       = xor_c;
                    dout_last_d  = work_last_q;
                    dout_bytes_d = work_bytes_q;
                    dout_valid_d = 1'b1;
                    state_d      = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        {work_last_d, work_bytes_d, work_data_d} = fifo_rd_data;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ks_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q      <= ST_IDLE;
            work_data_q  <= '0;
            work_last_q  <= 1'b0;
            work_bytes_q <= '0;
            dout_q       <= '0;
            dout_last_q  <= 1'b0;
            dout_bytes_q <= '0;
            dout_valid_q <= 1'b0;
            ks_req_q     <= 1'b0;
            err_ks_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_data_q  <= work_data_d;
            work_last_q  <= work_last_d;
            work_bytes_q <= work_bytes_d;
            dout_q       <= dout_d;
            dout_last_q  <= dout_last_d;
            dout_bytes_q <= dout_bytes_d;
            dout_valid_q <= dout_valid_d;
            ks_req_q     <= ks_req_d;
            err_ks_q     <= err_ks_d;
        end
    end

    assign din_ready  = !fifo_full;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign ks_req     = ks_req_q;
    assign dout       = dout_q;
    assign dout_last  = dout_last_q;
    assign dout_bytes = dout_bytes_q;
    assign dout_valid = dout_valid_q;
    assign err_ks     = err_ks_q;

endmodule

// File: tb/tb_ccm_ctr_xor_stage.sv
// Scoreboard bench for ccm_ctr_xor_stage with a delayed keystream responder model.
module tb_ccm_ctr_xor_stage;

    typedef struct packed {
        logic         last;
        logic [3:0]   bytes;
        logic [127:0] data;
    } sb_t;

    logic         clk = 1'b0;
    logic         kill_n;
    logic [127:0] din;
    logic         din_last;
    logic [3:0]   din_bytes;
    logic         din_valid;
    logic         din_ready;
    logic         ks_req;
    logic [127:0] ks_data;
    logic         ks_en;
    logic [127:0] dout;
    logic         dout_last;
    logic [3:0]   dout_bytes;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         err_ks;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ks_delay = 11;
    logic [127:0] ks_word = '0;
    int ks_kick_cnt = 0;
    int kick_seen = 0;
    int ks_req_cnt = 0;
    int err_cnt = 0;
    int vcnt = 0;
    int out_cnt = 0;
    int n_ovl = 0;
    int req_cyc = 0;
    int valid_cyc = 0;
    int acc_cyc = 0;
    logic outstanding = 1'b0;
    logic dv_prev = 1'b0;
    logic [127:0] last_dout = '0;
    sb_t sb[$];

    ccm_ctr_xor_stage dut (
        .clk        (clk),
        .kill_n     (kill_n),
        .din        (din),
        .din_last   (din_last),
        .din_bytes  (din_bytes),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ks_req     (ks_req),
        .ks_data    (ks_data),
        .ks_en      (ks_en),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_bytes (dout_bytes),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .err_ks     (err_ks)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic l, input logic [3:0] b);
        logic [127:0] r;
        r = d ^ k;
`ifdef CCM_CTR_BYTE_MASK_EN
        if (l && (b != 4'd0)) r = r & ~({128{1'b1}} >> (8 * b));
`endif
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Upstream keystream model: answers each ks_req after ks_delay cycles, or pulses on a kick.
    initial begin
        ks_en = 1'b0;
        ks_data = '0;
        forever begin
            @(negedge clk);
            if (ks_req) begin
                repeat (ks_delay) @(posedge clk);
                #1 ks_en = 1'b1; ks_data = ks_word;
                @(posedge clk);
                #1 ks_en = 1'b0; ks_data = '0;
            end else if (ks_kick_cnt != kick_seen) begin
                kick_seen = ks_kick_cnt;
                @(posedge clk);
                #1 ks_en = 1'b1; ks_data = ks_word;
                @(posedge clk);
                #1 ks_en = 1'b0; ks_data = '0;
            end
        end
    end

    // Output monitor: counts protocol events and compares accepted results against the scoreboard.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!kill_n) outstanding = 1'b0;
            if (ks_req) begin
                if (outstanding) n_ovl++;
                outstanding = 1'b1;
                ks_req_cnt++;
                req_cyc = cyc;
            end
            if (err_ks) err_cnt++;
            if (dout_valid) vcnt++;
            if (dout_valid && !dv_prev) valid_cyc = cyc;
            dv_prev = dout_valid;
            if (dout_valid && dout_ready && kill_n) begin
                outstanding = 1'b0;
                last_dout = dout;
                out_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.data);
                    check("dout_last", 128'(dout_last), 128'(e.last));
                    check("dout_bytes", 128'(dout_bytes), 128'(e.bytes));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers one block (leaves din_valid high for back-to-back use) and records the expectation.
    task automatic send(input logic [127:0] d, input logic l, input logic [3:0] b);
        int n;
        sb_t e;
        din = d; din_last = l; din_bytes = b; din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("din_accept", 128'(din_ready), 128'(1));
        acc_cyc = cyc;
        e.last = l; e.bytes = b; e.data = model(d, ks_word, l, b);
        sb.push_back(e);
        sync();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 128'(sb.size() == 0 && !busy), 128'(1));
    endtask

    initial begin
        int r0, e0, v0, o0;
        logic [127:0] held;
        int n;

        kill_n = 1'b0; din = '0; din_last = 1'b0; din_bytes = '0;
        din_valid = 1'b0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_din_ready", 128'(din_ready), 128'(1));
        check("rst_ks_req", 128'(ks_req), 128'(0));
        check("rst_dout_valid", 128'(dout_valid), 128'(0));
        check("rst_dout", dout, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err_ks", 128'(err_ks), 128'(0));
        sync();
        kill_n = 1'b1;
        repeat (2) sync();

        // 1: single block, ks all ones, 11-cycle keystream latency
        ks_word = {128{1'b1}}; ks_delay = 11;
        r0 = ks_req_cnt;
        send(128'h000102030405060708090A0B0C0D0E0F, 1'b0, 4'd0);
        din_valid = 1'b0;
        wait_idle(200);
        check("t1_req_latency", 128'(req_cyc - acc_cyc), 128'(2));
        check("t1_out_latency", 128'(valid_cyc - req_cyc), 128'(12));
        check("t1_req_count", 128'(ks_req_cnt - r0), 128'(1));
        check("t1_dout", last_dout, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

        // 2: five back-to-back blocks against a four-deep FIFO
        sync();
        ks_word = rand128(); ks_delay = 3;
        r0 = ks_req_cnt; o0 = out_cnt;
        for (int i = 0; i < 5; i++) send(rand128(), (i == 4), 4'd0);
        din_valid = 1'b0;
        @(negedge clk);
        check("t2_fifo_full", 128'(din_ready), 128'(0));
        wait_idle(500);
        check("t2_req_count", 128'(ks_req_cnt - r0), 128'(5));
        check("t2_out_count", 128'(out_cnt - o0), 128'(5));

        // 3: downstream stalls 20 cycles with a second block queued
        sync();
        dout_ready = 1'b0; ks_word = rand128(); ks_delay = 2;
        r0 = ks_req_cnt;
        send(rand128(), 1'b0, 4'd0);
        send(rand128(), 1'b1, 4'd7);
        din_valid = 1'b0;
        n = 0;
        while (!dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid", 128'(dout_valid), 128'(1));
        held = dout;
        repeat (20) begin
            @(negedge clk);
            check("t3_stable", dout, held);
        end
        check("t3_hold_valid", 128'(dout_valid), 128'(1));
        check("t3_single_req", 128'(ks_req_cnt - r0), 128'(1));
        sync();
        dout_ready = 1'b1;
        wait_idle(200);
        check("t3_req_count", 128'(ks_req_cnt - r0), 128'(2));

        // 4: stray keystream strobe while idle
        sync();
        e0 = err_cnt; v0 = vcnt;
        ks_kick_cnt++;
        repeat (4) @(negedge clk);
        check("t4_err_cycles", 128'(err_cnt - e0), 128'(1));
        check("t4_no_valid", 128'(vcnt - v0), 128'(0));
        check("t4_idle", 128'(busy), 128'(0));

        // 5: short final block, 0xAA ^ 0x55, three valid bytes
        sync();
        ks_word = {16{8'h55}}; ks_delay = 4;
        send({16{8'hAA}}, 1'b1, 4'd3);
        din_valid = 1'b0;
        wait_idle(200);
`ifdef CCM_CTR_BYTE_MASK_EN
        check("t5_dout", last_dout, 128'hFFFFFF00000000000000000000000000);
`else
        check("t5_dout", last_dout, {128{1'b1}});
`endif

        // 6: reset while waiting for keystream; the late strobe must only flag an error
        sync();
        ks_word = rand128(); ks_delay = 30;
        r0 = ks_req_cnt;
        send(rand128(), 1'b0, 4'd0);
        send(rand128(), 1'b1, 4'd5);
        din_valid = 1'b0;
        n = 0;
        while (ks_req_cnt == r0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #2 kill_n = 1'b0;
        sb.delete();
        #1;
        check("t6_ks_req", 128'(ks_req), 128'(0));
        check("t6_dout_valid", 128'(dout_valid), 128'(0));
        check("t6_dout", dout, 128'(0));
        check("t6_fifo_empty", 128'(busy), 128'(0));
        check("t6_din_ready", 128'(din_ready), 128'(1));
        repeat (2) sync();
        kill_n = 1'b1;
        e0 = err_cnt; v0 = vcnt; r0 = ks_req_cnt;
        repeat (35) @(negedge clk);
        check("t6_late_err", 128'(err_cnt - e0), 128'(1));
        check("t6_no_valid", 128'(vcnt - v0), 128'(0));
        check("t6_no_req", 128'(ks_req_cnt - r0), 128'(0));
        check("t6_idle", 128'(busy), 128'(0));

        // Recovery after reset
        sync();
        ks_word = rand128(); ks_delay = 1;
        send(rand128(), 1'b1, 4'd9);
        din_valid = 1'b0;
        wait_idle(200);

        check("one_outstanding", 128'(n_ovl), 128'(0));
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
